qmem_arbiter2: RTL
==================

# qmem_arbiter2

Two-master round-robin arbiter for a single QMEM slave port, clocked on qs_clk. It sits upstream of the QMEM frequency-down bridge, or of any QMEM slave, and lets two masters share it. Each granted transaction is locked to one master until the slave acks or errors. An optional watchdog terminates transactions the slave never acknowledges.

## Interface
Parameters:
- QAW, 32, address width
- QDW, 32, data width
- QSW, QDW/8, byte-select width
- TO_EN, 1, watchdog enable (0 = no timeout)
- TOW, 8, watchdog counter width; timeout after 2^TOW-1 unacknowledged cycles

Ports:
- qs_clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- m0_cs, m0_we  in  1  master 0 chip-select / write enable
- m0_sel  in  QSW  master 0 byte select
- m0_adr  in  QAW  master 0 address
- m0_dat_w  in  QDW  master 0 write data
- m0_dat_r  out  QDW  master 0 read data
- m0_ack, m0_err  out  1  master 0 acknowledge / error
- m1_*  same set as m0_*, for master 1
- s_cs, s_we  out  1  slave chip-select / write enable
- s_sel  out  QSW  slave byte select
- s_adr  out  QAW  slave address
- s_dat_w  out  QDW  slave write data
- s_dat_r  in  QDW  slave read data
- s_ack, s_err  in  1  slave acknowledge / error
- gnt  out  2  one-hot grant status (bit0 = m0, bit1 = m1, 00 = idle)
- to_evt  out  1  single-cycle watchdog timeout pulse

## Operation
- State register with three states: IDLE, G0, G1. Register last holds the last master served (0/1).
- IDLE:
  - only m0_cs -> G0; only m1_cs -> G1.
  - both -> the master != last.
  - neither -> stay.
- G0: s_* = m0_*, s_cs = m0_cs; m0_ack = s_ack, m0_err = s_err. Master 1 sees ack/err = 0.
- G1: mirror of G0.
- Transaction end in Gx is s_ack | s_err | timeout. On end: last <= x. Next state:
  - other master's cs high -> G(other).
  - else own cs high -> stay Gx (back-to-back burst).
  - else -> IDLE.
- Gx with mx_cs low and no end -> other cs ? G(other) : IDLE. This is a master abandoning before its first access; last is unchanged.
- m0_dat_r = m1_dat_r = s_dat_r, unconditionally. The ack gates validity.
- IDLE: s_cs = 0; s_we/s_sel/s_adr/s_dat_w = 0.
- Watchdog (TO_EN=1): counter to_cnt [TOW-1:0].
  - Cleared on any state change or transaction end.
  - Increments each cycle in Gx with s_cs=1 and !s_ack & !s_err.
  - When to_cnt == all-ones and neither s_ack nor s_err: that cycle mx_err = 1, mx_ack = 0, to_evt = 1, and the cycle is treated as transaction end.
  - Saturation: the counter never wraps; it clears at the end.
- TO_EN=0: to_cnt is held at 0 and to_evt = 0.
- gnt reflects the registered state: G0 -> 01, G1 -> 10, IDLE -> 00.

## Timing
- Reset values: state IDLE, last = 1 (m0 wins the first tie), to_cnt = 0.
  - Outputs during reset: gnt = 00, to_evt = 0, s_cs = 0, m*_ack = m*_err = 0.
- Arbitration latency: cs seen in IDLE at cycle N -> gnt and s_cs at N+1.
- Once granted, master-to-slave and slave-to-master paths are combinational, adding zero cycles.
- Re-arbitration at transaction end has no IDLE bubble. A same-cycle handover asserts the next master's s_cs in cycle N+1 after the ack in cycle N.
- Slave ack in the same cycle as grant entry (N+1) is legal; it ends the transaction immediately.
- s_ack and s_err together: both pass through, and the cycle counts as a single end.
- s_ack arriving in the exact timeout cycle: the ack wins; no err, no to_evt.
- Asynchronous reset mid-transaction: s_cs drops immediately; a pending ack is discarded.

## Test plan
- Reset: assert rst with m0_cs = m1_cs = 1 -> s_cs = 0, gnt = 00, all acks/errs 0. Release -> gnt = 01 one cycle later.
- Single master: m1_cs high at N with adr = 0x100, slave acks at N+2 -> gnt = 10 at N+1, m1_ack at N+2, m0_ack stays 0, s_adr = 0x100.
- Contention round-robin: both cs held high, slave acks every cycle -> gnt sequence 01,10,01,10. Each master receives an ack on alternate cycles.
- Burst with idle competitor: m0 issues 4 back-to-back reads, m1_cs low -> gnt stays 01 for all 4 with no bubble. m1_cs rising mid-burst -> gnt = 10 the cycle after the next m0 ack.
- Watchdog: TOW = 3, m0 granted, slave never acks -> m0_err = 1 and to_evt = 1 on the 8th granted cycle (to_cnt = 7), then IDLE. In a second run, s_ack in that same cycle -> m0_ack = 1, m0_err = 0, to_evt = 0.
- Abandon: m0 granted, m0_cs drops before any ack while m1_cs is high -> gnt = 10 the next cycle, last still 1.

Source files
------------

// File: rtl/qmem_arbiter2.sv
// qmem_arbiter2: two-master round-robin arbiter for one QMEM slave port with an optional watchdog
module qmem_arbiter2 #(
  parameter int QAW   = 32,
  parameter int QDW   = 32,
  parameter int QSW   = QDW/8,
  parameter int TO_EN = 1,
  parameter int TOW   = 8
)(
  input  logic           qs_clk,
  input  logic           rst,
  input  logic           m0_cs,
  input  logic           m0_we,
  input  logic [QSW-1:0] m0_sel,
  input  logic [QAW-1:0] m0_adr,
  input  logic [QDW-1:0] m0_dat_w,
  output logic [QDW-1:0] m0_dat_r,
  output logic           m0_ack,
  output logic           m0_err,
  input  logic           m1_cs,
  input  logic           m1_we,
  input  logic [QSW-1:0] m1_sel,
  input  logic [QAW-1:0] m1_adr,
  input  logic [QDW-1:0] m1_dat_w,
  output logic [QDW-1:0] m1_dat_r,
  output logic           m1_ack,
  output logic           m1_err,
  output logic           s_cs,
  output logic           s_we,
  output logic [QSW-1:0] s_sel,
  output logic [QAW-1:0] s_adr,
  output logic [QDW-1:0] s_dat_w,
  input  logic [QDW-1:0] s_dat_r,
  input  logic           s_ack,
  input  logic           s_err,
  output logic [1:0]     gnt,
  output logic           to_evt
);
  typedef enum logic [1:0] {IDLE, G0, G1} state_t;
  state_t         state_q, state_d;
  logic           last_q, last_d;
  logic [TOW-1:0] to_cnt_q, to_cnt_d;
  logic           g0, g1, own, oth, tmo, fin;
  assign m0_dat_r = s_dat_r;
  assign m1_dat_r = s_dat_r;
  assign gnt      = {g1, g0};
  always_comb begin
    g0      = state_q == G0;
    g1      = state_q == G1;
    own     = g0 ? m0_cs : m1_cs;
    oth     = g0 ? m1_cs : m0_cs;
    s_cs    = g0 ? m0_cs    : g1 ? m1_cs    : 1'b0;
    s_we    = g0 ? m0_we    : g1 ? m1_we    : 1'b0;
    s_sel   = g0 ? m0_sel   : g1 ? m1_sel   : '0;
    s_adr   = g0 ? m0_adr   : g1 ? m1_adr   : '0;
    s_dat_w = g0 ? m0_dat_w : g1 ? m1_dat_w : '0;
    // A same-cycle ack beats the watchdog
    tmo     = (TO_EN != 0) && s_cs && (&to_cnt_q) && !s_ack && !s_err;
    fin     = (g0 || g1) && (s_ack || s_err || tmo);
    m0_ack  = g0 && s_ack;
    m1_ack  = g1 && s_ack;
    m0_err  = g0 && (s_err || tmo);
    m1_err  = g1 && (s_err || tmo);
    to_evt  = tmo;
    state_d = (state_q == IDLE) ?
                ((m0_cs && m1_cs) ? (last_q ? G0 : G1) : m0_cs ? G0 : m1_cs ? G1 : IDLE) :
                ((own && !(fin && oth)) ? state_q : oth ? (g0 ? G1 : G0) : IDLE);
    last_d  = fin ? g1 : last_q;
    to_cnt_d = (TO_EN == 0 || fin || state_d != state_q) ? '0 :
               (s_cs && !s_ack && !s_err && !(&to_cnt_q)) ? to_cnt_q + 1'b1 : to_cnt_q;
  end
  always_ff @(posedge qs_clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      to_cnt_q <= to_cnt_d;
    end
  end
endmodule
